// File: rtl/instr_fetch_unit.sv
// MIPS-32 IF stage: PC, req/ack instruction fetch, IF/ID register with a
// one-entry skid buffer, and combinational field split for the ID stage.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [1:0]  instr_type
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_old_addr;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;

    state_t      w_state_n;
    logic [31:0] w_pc_n;
    logic [31:0] w_old_addr_n;
    logic        w_ifid_valid_n;
    logic [31:0] w_ifid_pc_n;
    logic [31:0] w_ifid_instr_n;
    logic        w_skid_valid_n;
    logic [31:0] w_skid_pc_n;
    logic [31:0] w_skid_instr_n;

    logic        w_req;
    logic        w_ack;
    logic        w_slot_free;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redirect_tgt;
    logic        w_unused;

    // r_run keeps imem_req low until the first edge after reset release
    assign w_req          = r_run && (r_state != S_HOLD);
    assign w_ack          = imem_ack && w_req;
    assign w_slot_free    = !r_ifid_valid || !id_stall;
    assign w_pc_inc       = r_pc + 32'd4;
    assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign w_unused       = ^redirect_pc[1:0];

    assign imem_req  = w_req;
    assign imem_addr = (r_state == S_DISCARD) ? r_old_addr : r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_run        <= 1'b0;
            r_pc         <= PC_INIT;
            r_old_addr   <= 32'd0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= 32'd0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
        end else begin
            r_state      <= w_state_n;
            r_run        <= 1'b1;
            r_pc         <= w_pc_n;
            r_old_addr   <= w_old_addr_n;
            r_ifid_valid <= w_ifid_valid_n;
            r_ifid_pc    <= w_ifid_pc_n;
            r_ifid_instr <= w_ifid_instr_n;
            r_skid_valid <= w_skid_valid_n;
            r_skid_pc    <= w_skid_pc_n;
            r_skid_instr <= w_skid_instr_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_old_addr_n   = r_old_addr;
        w_ifid_valid_n = r_ifid_valid;
        w_ifid_pc_n    = r_ifid_pc;
        w_ifid_instr_n = r_ifid_instr;
        w_skid_valid_n = r_skid_valid;
        w_skid_pc_n    = r_skid_pc;
        w_skid_instr_n = r_skid_instr;

        if (redirect_valid) begin
            w_pc_n         = w_redirect_tgt;
            w_ifid_valid_n = 1'b0;
            w_skid_valid_n = 1'b0;
            // an outstanding unacked request must still finish at its old address
            if (w_req && !w_ack) begin
                w_state_n    = S_DISCARD;
                w_old_addr_n = imem_addr;
            end else begin
                w_state_n = S_REQ;
            end
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        w_pc_n = w_pc_inc;
                        if (w_slot_free) begin
                            w_ifid_valid_n = 1'b1;
                            w_ifid_pc_n    = r_pc;
                            w_ifid_instr_n = imem_rdata;
                        end else begin
                            w_skid_valid_n = 1'b1;
                            w_skid_pc_n    = r_pc;
                            w_skid_instr_n = imem_rdata;
                            w_state_n      = S_HOLD;
                        end
                    end else if (r_ifid_valid && !id_stall) begin
                        w_ifid_valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        w_ifid_valid_n = r_skid_valid;
                        w_ifid_pc_n    = r_skid_pc;
                        w_ifid_instr_n = r_skid_instr;
                        w_skid_valid_n = 1'b0;
                        w_state_n      = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (w_ack) begin
                        w_state_n = S_REQ;
                    end
                end
                default: begin
                    w_state_n = S_REQ;
                end
            endcase
        end
    end

    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;

    assign opcode = r_ifid_instr[31:26];
    assign rs     = r_ifid_instr[25:21];
    assign rt     = r_ifid_instr[20:16];
    assign rd     = r_ifid_instr[15:11];
    assign sa     = r_ifid_instr[10:6];
    assign funct  = r_ifid_instr[5:0];
    assign imm    = r_ifid_instr[15:0];

    always_comb begin
        instr_type = 2'b01;
        unique case (1'b1)
            (opcode == 6'd0): instr_type = 2'b00;
            (opcode == 6'd2),
            (opcode == 6'd3): instr_type = 2'b10;
            default:          instr_type = 2'b01;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing checks plus a randomized run
// scored against an architectural next-PC model.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, sa;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [1:0]  instr_type;

    logic        req1, ack1, valid1;
    logic [31:0] addr1, rdata1, pc1, instr1;
    logic [5:0]  op1, fn1;
    logic [4:0]  rs1, rt1, rd1, sa1;
    logic [15:0] imm1;
    logic [1:0]  type1;

    int checks = 0;
    int errors = 0;
    int lat_fixed = 0;
    int consumed = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0011;
            32'h4:   return 32'h0000_0022;
            32'h8:   return 32'h0000_0033;
            32'h300: return 32'h012A_4020;
            32'h304: return 32'h0800_0010;
            32'h308: return 32'h8D28_0004;
            default: return {~a[15:0], a[17:2]} ^ 32'h3C5A_0000;
        endcase
    endfunction

    function automatic logic [1:0] ref_type(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'd0) return 2'b00;
        if (op == 6'd2 || op == 6'd3) return 2'b10;
        return 2'b01;
    endfunction

    instr_fetch_unit u0 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
        .funct(funct), .imm(imm), .instr_type(instr_type)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst(rst),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack1), .imem_rdata(rdata1),
        .id_stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .ifid_valid(valid1), .ifid_pc(pc1), .ifid_instr(instr1),
        .opcode(op1), .rs(rs1), .rt(rt1), .rd(rd1), .sa(sa1),
        .funct(fn1), .imm(imm1), .instr_type(type1)
    );

    assign ack1   = req1;
    assign rdata1 = word_at(addr1);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // reference model: ID must see consecutive words from the last (re)start
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = model_pc;
            e.instr = word_at(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = {pc[31:2], 2'b00};
        top_up();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        top_up();
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // memory with per-request latency, fixed or random 0..3 wait cycles
    int wait_cnt = 0;
    int cur_lat = 0;
    always @(posedge clk) begin
        #2;
        if (rst) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (imem_req) begin
            if (wait_cnt == 0)
                cur_lat = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
            if (wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
        end
    end

    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          stall_acks = 0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_pend  = 1'b0;
            stall_acks = 0;
        end else begin
            if (prev_pend && imem_req)
                chk("addr_stable", imem_addr, prev_addr);
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (redirect_valid || !id_stall) begin
                stall_acks = 0;
            end else if (ifid_valid && imem_ack) begin
                stall_acks++;
                chk("stall_fetch_limit", 32'(stall_acks <= 1), 32'd1);
            end
            if (ifid_valid && !id_stall && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=pc %h expected=none", ifid_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    consumed++;
                    chk("sb_pc", ifid_pc, mon_e.pc);
                    chk("sb_instr", ifid_instr, mon_e.instr);
                    chk("sb_opcode", 32'(opcode), 32'(mon_e.instr[31:26]));
                    chk("sb_rt", 32'(rt), 32'(mon_e.instr[20:16]));
                    chk("sb_imm", 32'(imm), 32'(mon_e.instr[15:0]));
                    chk("sb_type", 32'(instr_type), 32'(ref_type(mon_e.instr)));
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        lat_fixed      = 0;
        model_restart(32'd0);

        at_neg();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);
        chk("rst_type", 32'(instr_type), 32'd0);
        chk("rst_req_u1", 32'(req1), 32'd0);

        tick();
        rst = 1'b0;
        model_restart(32'd0);
        at_neg();
        chk("req_before_edge", 32'(imem_req), 32'd0);

        tick();
        at_neg();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("wrap_addr0", addr1, 32'hFFFF_FFF8);
        tick();
        at_neg();
        chk("zw_instr0", ifid_instr, 32'h11);
        chk("zw_pc0", ifid_pc, 32'h0);
        chk("zw_addr4", imem_addr, 32'h4);
        chk("wrap_addr1", addr1, 32'hFFFF_FFFC);
        tick();
        at_neg();
        chk("zw_instr1", ifid_instr, 32'h22);
        chk("zw_pc1", ifid_pc, 32'h4);
        chk("zw_addr8", imem_addr, 32'h8);
        chk("wrap_addr2", addr1, 32'h0);
        chk("wrap_pc1", pc1, 32'hFFFF_FFFC);

        tick();
        id_stall = 1'b1;
        at_neg();
        chk("zw_instr2", ifid_instr, 32'h33);
        chk("skid_ack", 32'(imem_ack), 32'd1);
        repeat (2) begin
            tick();
            at_neg();
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_pc", ifid_pc, 32'h8);
            chk("stall_valid", 32'(ifid_valid), 32'd1);
        end
        tick();
        id_stall = 1'b0;
        at_neg();
        chk("release_pc", ifid_pc, 32'h8);
        chk("release_req", 32'(imem_req), 32'd0);
        tick();
        at_neg();
        chk("skid_pc", ifid_pc, 32'hC);
        chk("skid_instr", ifid_instr, word_at(32'hC));
        chk("skid_req", 32'(imem_req), 32'd1);

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        model_restart(32'h40);
        tick();
        redirect_valid = 1'b0;
        lat_fixed      = 3;
        at_neg();
        chk("lat_addr_a", imem_addr, 32'h40);
        chk("lat_valid_a", 32'(ifid_valid), 32'd0);
        chk("lat_ack_a", 32'(imem_ack), 32'd0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        model_restart(32'h100);
        at_neg();
        chk("lat_addr_b", imem_addr, 32'h40);
        tick();
        redirect_valid = 1'b0;
        at_neg();
        chk("disc_addr", imem_addr, 32'h40);
        chk("disc_req", 32'(imem_req), 32'd1);
        chk("disc_valid", 32'(ifid_valid), 32'd0);
        tick();
        lat_fixed = 0;
        at_neg();
        chk("disc_ack", 32'(imem_ack), 32'd1);
        chk("disc_addr_ack", imem_addr, 32'h40);
        tick();
        at_neg();
        chk("tgt_addr", imem_addr, 32'h100);
        chk("tgt_valid", 32'(ifid_valid), 32'd0);
        tick();
        at_neg();
        chk("tgt_pc", ifid_pc, 32'h100);
        chk("tgt_live", 32'(ifid_valid), 32'd1);

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        model_restart(32'h203);
        at_neg();
        chk("rd_ack_same", 32'(imem_ack), 32'd1);
        tick();
        redirect_valid = 1'b0;
        at_neg();
        chk("rd_addr", imem_addr, 32'h200);
        chk("rd_valid", 32'(ifid_valid), 32'd0);
        tick();
        at_neg();
        chk("rd_pc", ifid_pc, 32'h200);

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        model_restart(32'h300);
        tick();
        redirect_valid = 1'b0;
        tick();
        at_neg();
        chk("dec_opcode", 32'(opcode), 32'd0);
        chk("dec_rs", 32'(rs), 32'd9);
        chk("dec_rt", 32'(rt), 32'd10);
        chk("dec_rd", 32'(rd), 32'd8);
        chk("dec_sa", 32'(sa), 32'd0);
        chk("dec_funct", 32'(funct), 32'h20);
        chk("dec_type_r", 32'(instr_type), 32'd0);
        tick();
        at_neg();
        chk("dec_type_j", 32'(instr_type), 32'd2);
        tick();
        at_neg();
        chk("dec_type_i", 32'(instr_type), 32'd1);
        chk("dec_imm", 32'(imm), 32'h4);
        chk("dec_op_lw", 32'(opcode), 32'h23);

        lat_fixed = -1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            id_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                model_restart(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
            if (i == 2000) begin
                redirect_valid = 1'b0;
                id_stall       = 1'b0;
                #2;
                rst = 1'b1;
                model_restart(32'd0);
                #1;
                chk("async_valid", 32'(ifid_valid), 32'd0);
                chk("async_req", 32'(imem_req), 32'd0);
                chk("async_pc", ifid_pc, 32'd0);
                tick();
                tick();
                rst = 1'b0;
                model_restart(32'd0);
            end
        end

        tick();
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        repeat (10) tick();
        chk("consumed_min", 32'(consumed > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

IF-stage instruction fetch unit for the MIPS-32 pipeline. It owns the program counter, fetches words from instruction memory over a req/ack handshake, and holds them in the IF/ID register. It drives the field-split instruction (opcode, rs, rt, rd, sa, funct, immediate, instruction type) into the ID-stage control unit. It honours ID-stage stalls and branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] forced to 0)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  word address of current request; stable while imem_req && !imem_ack
- imem_ack  in  1  memory accepted request and imem_rdata valid this cycle
- imem_rdata  in  32  instruction word, valid only with imem_ack
- id_stall  in  1  ID cannot consume IF/ID contents this cycle
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  target PC; bits [1:0] ignored (treated 0)
- ifid_valid  out  1  IF/ID register holds a live instruction
- ifid_pc  out  32  PC of instruction in IF/ID
- ifid_instr  out  32  instruction in IF/ID
- opcode  out  6  ifid_instr[31:26]
- rs / rt / rd / sa  out  5 each  ifid_instr[25:21] / [20:16] / [15:11] / [10:6]
- funct  out  6  ifid_instr[5:0]
- imm  out  16  ifid_instr[15:0]
- instr_type  out  2  00 R (opcode 0), 10 J (opcode 2 or 3), 01 I (all others); 11 never driven

## Operation
- State: pc (32b), FSM {REQ, HOLD, DISCARD}, IF/ID register, one-entry skid buffer (skid_valid, skid_pc, skid_instr).
- Reset: pc=RESET_PC, state REQ, imem_req=0 during reset, ifid_valid=0, ifid_pc=0, ifid_instr=0 (field outputs 0, instr_type=00), skid_valid=0.
- REQ: imem_req=1, imem_addr=pc. On imem_ack:
  - If the slot is free (!ifid_valid || !id_stall): load IF/ID with {pc, imem_rdata}, ifid_valid=1, pc+=4, stay REQ.
  - Otherwise: capture into skid, pc+=4, go HOLD.
  - No ack and slot consumed (ifid_valid && !id_stall): ifid_valid=0.
- HOLD: imem_req=0. When !id_stall, skid moves to IF/ID, skid_valid=0, go REQ.
- DISCARD: imem_req=1 with the old address held. On imem_ack, drop data, go REQ (pc already holds target).
- Redirect (highest priority, any state):
  - pc=redirect_pc & ~3, ifid_valid=0, skid_valid=0.
  - Next state: DISCARD if in REQ without ack this cycle, otherwise REQ.
  - Data acked in the redirect cycle is dropped.
  - id_stall is ignored in the redirect cycle.
- Addresses wrap: 32'hFFFF_FFFC + 4 = 0.
- Field and type outputs are combinational from ifid_instr. Valid meaning is qualified by ifid_valid.

## Timing
- First imem_req=1 on the first rising edge after rst deasserts, with imem_addr=RESET_PC.
- Memory may ack in the same cycle req is high (zero-wait). Back-to-back acks give 1 instruction/cycle.
- Fetch latency is 1 cycle: data acked at edge N appears on ifid_* after edge N.
- Stall: IF/ID and skid contents are held unchanged. At most one further word is fetched, into skid; then imem_req=0 until the stall drops.
- Stall release from HOLD: skid reaches IF/ID 1 cycle later, and imem_req reasserts in the same cycle.
- Redirect at edge N: ifid_valid=0 after N.
  - From REQ/ack or HOLD: imem_addr=target after N.
  - From DISCARD: imem_addr=target the cycle after the pending ack.
- Async rst mid-transaction: outputs go to reset values immediately. Any pending memory ack is not tracked (the memory must also be reset).

## Test plan
- Reset, then zero-wait memory returning 0x11, 0x22, 0x33: imem_addr 0,4,8 on consecutive cycles; ifid_instr 0x11/0x22/0x33 with ifid_pc 0/4/8, one per cycle.
- id_stall held 3 cycles with ifid_valid=1: IF/ID unchanged, one word goes to skid, imem_req=0. On release, the skid word appears next cycle with correct pc; no word is lost or duplicated.
- 3-cycle memory latency on addr 0x40, with redirect to 0x100 on its second wait cycle: imem_addr stays 0x40 until ack, data dropped, next request at 0x100, ifid_valid=0 throughout.
- Redirect to 0x203 in the same cycle as an ack: acked word dropped, next imem_addr=0x200.
- Instruction 0x012A4020: opcode 0, rs 9, rt 10, rd 8, sa 0, funct 0x20, instr_type 00. Instruction 0x08000010: instr_type 10. Instruction 0x8D280004: instr_type 01, imm 0x0004.
- RESET_PC=32'hFFFF_FFF8: fetches at FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting rst mid-stream gives ifid_valid=0 and imem_req=0 immediately.
